// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block as 16 words, then streams
// W_t and K_t for rounds 0..63 through a 16-word sliding window with backpressure.
module sha256_msg_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        first_blk_i,
    input  logic        msg_valid_i,
    input  logic [31:0] msg_data_i,
    output logic        msg_ready_o,
    output logic        ld_o,
    output logic        wt_valid_o,
    input  logic        round_ready_i,
    output logic [31:0] wt_o,
    output logic [31:0] kt_o,
    output logic [5:0]  round_o,
    output logic        busy_o,
    output logic        done_o
);
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {IDLE, LOAD, INIT, RUN, DONE} state_t;

    localparam logic [DATA_W-1:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        word_cnt;
    logic              first_blk;
    logic [5:0]        round;
    logic [DATA_W-1:0] win [16];
    logic              word_acc;
    logic              round_acc;
    logic [DATA_W-1:0] w_new;

    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
        return (x >> n) | (x << (DATA_W - n));
    endfunction

    function automatic logic [DATA_W-1:0] sigma0(input logic [DATA_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [DATA_W-1:0] sigma1(input logic [DATA_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign msg_ready_o = (state == LOAD);
    assign ld_o        = (state == INIT) && first_blk;
    assign wt_valid_o  = (state == RUN);
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);
    assign round_o     = round;
    // K/W are forced to zero outside RUN so idle and reset outputs read as 0
    assign wt_o        = wt_valid_o ? win[0] : '0;
    assign kt_o        = wt_valid_o ? K[round] : '0;

    assign word_acc  = msg_valid_i && msg_ready_o;
    assign round_acc = wt_valid_o && round_ready_i;
    assign w_new     = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = LOAD;
            LOAD:    if (word_acc && (word_cnt == 4'd15)) state_nxt = INIT;
            INIT:    state_nxt = RUN;
            RUN:     if (round_acc && (round == 6'd63)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt  <= '0;
            first_blk <= 1'b0;
            round     <= '0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else begin
            if ((state == IDLE) && start_i) begin
                word_cnt  <= '0;
                first_blk <= first_blk_i;
                round     <= '0;
            end
            if (word_acc) begin
                win[word_cnt] <= msg_data_i;
                word_cnt      <= word_cnt + 4'd1;
            end
            // round 63 wraps the counter to 0 only as the FSM leaves RUN
            if (round_acc) begin
                for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                win[15] <= w_new;
                round   <= round + 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: "abc" and a second block under stalls,
// load gaps, stray inputs, no-IV-load, and a mid-run reset abort.
module tb_sha256_msg_schedule;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_i = 1'b0;
    logic        first_blk_i = 1'b0;
    logic        msg_valid_i = 1'b0;
    logic [31:0] msg_data_i = '0;
    logic        round_ready_i = 1'b0;
    logic        msg_ready_o;
    logic        ld_o;
    logic        wt_valid_o;
    logic [31:0] wt_o;
    logic [31:0] kt_o;
    logic [5:0]  round_o;
    logic        busy_o;
    logic        done_o;

    sha256_msg_schedule dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .first_blk_i(first_blk_i),
        .msg_valid_i(msg_valid_i), .msg_data_i(msg_data_i), .msg_ready_o(msg_ready_o),
        .ld_o(ld_o), .wt_valid_o(wt_valid_o), .round_ready_i(round_ready_i),
        .wt_o(wt_o), .kt_o(kt_o), .round_o(round_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] KREF [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] blk [16];
    logic [31:0] ref_w [64];
    logic [31:0] acc_wt [128];
    logic [31:0] acc_kt [128];
    logic [5:0]  acc_rnd [128];
    int          n_acc;
    int          ld_cnt;
    int          done_cnt;
    bit          finished;
    bit          aborted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    task automatic compute_ref();
        for (int t = 0; t < 64; t++)
            ref_w[t] = (t < 16) ? blk[t] : s1(ref_w[t-2]) + ref_w[t-7] + s0(ref_w[t-15]) + ref_w[t-16];
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ready"}, 32'(msg_ready_o), 32'd0);
        chk({tag, "_ld"},    32'(ld_o),        32'd0);
        chk({tag, "_valid"}, 32'(wt_valid_o),  32'd0);
        chk({tag, "_wt"},    wt_o,             32'd0);
        chk({tag, "_kt"},    kt_o,             32'd0);
        chk({tag, "_round"}, 32'(round_o),     32'd0);
        chk({tag, "_busy"},  32'(busy_o),      32'd0);
        chk({tag, "_done"},  32'(done_o),      32'd0);
    endtask

    task automatic run_block(input bit first, input bit stall, input bit gaps, input bit noise, input int abort_round);
        int          widx;
        bit          prev_stall;
        logic [31:0] pw;
        logic [31:0] pk;
        logic [5:0]  pr;
        widx = 0; n_acc = 0; ld_cnt = 0; done_cnt = 0;
        finished = 0; aborted = 0; prev_stall = 0; pw = '0; pk = '0; pr = '0;
        @(negedge clk);
        start_i = 1'b1; first_blk_i = first;
        @(negedge clk);
        start_i = 1'b0; first_blk_i = 1'b0;
        for (int cyc = 0; cyc < 3000 && !finished && !aborted; cyc++) begin
            ld_cnt += int'(ld_o);
            if (prev_stall) begin
                chk("stall_hold_wt", wt_o, pw);
                chk("stall_hold_kt", kt_o, pk);
                chk("stall_hold_round", 32'(round_o), 32'(pr));
            end
            prev_stall = 0;
            if (done_o) begin
                done_cnt++;
                finished = 1;
            end
            if (msg_ready_o && widx < 16) begin
                msg_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                msg_data_i  = blk[widx];
                if (msg_valid_i) widx++;
            end else begin
                msg_valid_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                msg_data_i  = $urandom;
            end
            if (wt_valid_o && abort_round >= 0 && int'(round_o) == abort_round) begin
                rst_n = 1'b0; round_ready_i = 1'b0; msg_valid_i = 1'b0; start_i = 1'b0;
                #1;
                chk_zero_outputs("abort");
                aborted = 1;
            end else if (wt_valid_o) begin
                round_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (round_ready_i) begin
                    if (n_acc < 128) begin
                        acc_wt[n_acc] = wt_o; acc_kt[n_acc] = kt_o; acc_rnd[n_acc] = round_o;
                    end
                    n_acc++;
                end else begin
                    prev_stall = 1; pw = wt_o; pk = kt_o; pr = round_o;
                end
            end else begin
                round_ready_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (!aborted) begin
                start_i = (noise && (wt_valid_o || done_o)) ? 1'b1 : 1'b0;
                if (!finished) @(negedge clk);
            end
        end
        if (aborted) begin
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            chk("block_finished", 32'(finished), 32'd1);
        end
        @(negedge clk);
        start_i = 1'b0; msg_valid_i = 1'b0; round_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("post_busy", 32'(busy_o), 32'd0);
            chk("post_done", 32'(done_o), 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic check_results(input bit first);
        chk("accepted_rounds", 32'(n_acc), 32'd64);
        chk("ld_pulses", 32'(ld_cnt), 32'(first));
        chk("done_pulses", 32'(done_cnt), 32'd1);
        for (int t = 0; t < 64 && t < n_acc; t++) begin
            chk($sformatf("round_idx_%0d", t), 32'(acc_rnd[t]), 32'(t));
            chk($sformatf("wt_%0d", t), acc_wt[t], ref_w[t]);
            chk($sformatf("kt_%0d", t), acc_kt[t], KREF[t]);
        end
    endtask

    task automatic load_abc();
        for (int k = 0; k < 16; k++) blk[k] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        compute_ref();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_zero_outputs("reset");
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        load_abc();
        run_block(1'b1, 1'b0, 1'b0, 1'b0, -1);
        check_results(1'b1);
        chk("abc_w0",  acc_wt[0],  32'h61626380);
        chk("abc_k0",  acc_kt[0],  32'h428a2f98);
        chk("abc_w15", acc_wt[15], 32'h00000018);
        chk("abc_w16", acc_wt[16], 32'h61626380);
        chk("abc_w17", acc_wt[17], 32'h000f0000);
        chk("abc_w18", acc_wt[18], 32'h7da86405);
        chk("abc_w19", acc_wt[19], 32'h600003c6);
        chk("abc_k63", acc_kt[63], 32'hc67178f2);

        run_block(1'b1, 1'b1, 1'b1, 1'b1, -1);
        check_results(1'b1);

        run_block(1'b0, 1'b1, 1'b0, 1'b0, -1);
        check_results(1'b0);

        for (int k = 0; k < 16; k++) blk[k] = (32'h9e3779b9 * 32'(k + 1)) ^ 32'h5a5a0f0f;
        compute_ref();
        run_block(1'b1, 1'b1, 1'b1, 1'b1, -1);
        check_results(1'b1);

        run_block(1'b1, 1'b0, 1'b0, 1'b0, 30);
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        load_abc();
        run_block(1'b1, 1'b1, 1'b0, 1'b1, -1);
        check_results(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
